sample_packer: RTL and testbench
================================

Name: sample_packer

Overview:
- Parametrised successor to the fixed 3-channel, 3-mode sample multiplexer that feeds the packet streamer.
- Each cycle it accepts quantized 2-bit I/Q from NCH RF channels, plus raw 8-bit I/Q.
- It packs the selected stream MSB-first into 16-bit words with a valid strobe and a packet-end flag. Its outputs drive packet_streamer's source_data, source_en and source_packet_end.
- Mode and channel select take effect only at packet boundaries, so a packet never mixes formats.

Parameters:
- NCH, 3, number of RF channels (1..8).
- PKT_WORDS, 720, 16-bit words per packet (≥2).
- SELW, 3, width of channel select (≥ clog2(NCH), min 1).

Ports:
- clk  in  1  sample clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  streaming enable (from CPU port)
- mode_in  in  2  0=2-bit I/Q all channels, 1=8-bit I of sel, 2=8-bit Q of sel, 3=8-bit I+Q of sel
- sel_in  in  SELW  channel select for modes 1-3
- si  in  2*NCH  2-bit I per channel, channel 0 in [1:0]
- sq  in  2*NCH  2-bit Q per channel
- i8  in  8*NCH  8-bit I per channel, channel 0 in [7:0]
- q8  in  8*NCH  8-bit Q per channel
- out_data  out  16  packed word
- out_en  out  1  out_data valid this cycle
- out_end  out  1  last word of packet (only with out_en)
- packet_count  out  16  completed packets, wraps 0xFFFF→0
- active_mode  out  2  mode latched for current packet

Behaviour:
- Reset (async assert, sync release): out_data=0, out_en=0, out_end=0, packet_count=0, active_mode=0, fill=0, word counter=0, state IDLE.
- States: IDLE, RUN.
  - IDLE: no output, inputs ignored.
  - IDLE, enable=1: latch mode_in/sel_in into active_mode/active_sel, clear fill and word counter, go to RUN. The first input is captured on the next cycle.
- Per-cycle contribution in RUN, MSB-first:
  - mode 0: NCH*4 bits {si[0],sq[0],si[1],sq[1],...}.
  - mode 1: i8[sel], 8 bits.
  - mode 2: q8[sel], 8 bits.
  - mode 3: {i8[sel],q8[sel]}, 16 bits.
- Accumulator: holds fill bits, fill < 16 between cycles.
  - New bits append below existing bits.
  - When fill+k ≥ 16, the top 16 bits are emitted and the remainder is kept.
  - Width ≥ 15 + max(4*NCH, 16).
- Latency: the input bit that completes a word, present at cycle t, appears on out_data with out_en=1 at t+1. Outputs are registered.
- Cadence examples:
  - NCH=3, mode 0: 3 words per 4 cycles (pattern 1,1,1,0).
  - Modes 1/2: one word every 2nd cycle.
  - Mode 3: one word every cycle.
- Word counter counts emitted words 0..PKT_WORDS-1. out_end=1 with the word where counter==PKT_WORDS-1; counter then wraps to 0 and packet_count increments in the same cycle.
- Packet boundary, evaluated on the cycle that emits the out_end word:
  - enable=0: go to IDLE, clear fill. Remaining partial bits are discarded.
  - enable=1 and {mode_in,sel_in} equal to latched values: continue, keep fill.
  - enable=1 and either differs: relatch, clear fill. The current cycle's input bits beyond the emitted word are discarded.
- enable deasserted mid-packet: the packet runs to completion. No truncated packets.
- mode_in/sel_in changes mid-packet: ignored until the boundary.
- sel_in ≥ NCH at latch: treated as channel 0.
- out_en is never high in IDLE. out_end is never high without out_en.

Test Plan:
- NCH=3, PKT_WORDS=6, mode 0; si=sq=2'b01 for ch0, 2'b10 for ch1, 2'b11 for ch2, constant -> words 0x5AF5, 0xAF5A, 0xF5AF repeat with en pattern 1,1,1,0; out_end on 6th word; packet_count=1.
- Mode 1, sel=1, i8[1] ramps 0x00,0x01,0x02,... -> words 0x0001, 0x0203, ... on alternate cycles; first word 1 cycle after 2nd sample.
- Mode 3, sel=2, i8[2]=0x12, q8[2]=0x34 -> 0x1234 every cycle; out_end every PKT_WORDS cycles.
- mode_in 0→3 mid-packet -> remaining words of the packet still mode 0; mode 3 words start in the next packet; active_mode changes on the boundary cycle.
- enable dropped mid-packet -> packet completes with out_end, then out_en stays 0; re-enable -> word counter restarts at 0.
- reset_n pulsed low mid-packet (asynchronous, between edges) -> all outputs 0 immediately; packet_count=0; resumes from IDLE after release.

Source files
------------

// File: rtl/sample_packer.sv
// sample_packer: packs 2-bit multi-channel or 8-bit single-channel I/Q samples MSB-first
// into 16-bit packet words; mode/select are latched only at packet boundaries.
module sample_packer #(
   parameter int NCH       = 3,
   parameter int PKT_WORDS = 720,
   parameter int SELW      = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [1:0]        mode_in,
   input  logic [SELW-1:0]   sel_in,
   input  logic [2*NCH-1:0]  si,
   input  logic [2*NCH-1:0]  sq,
   input  logic [8*NCH-1:0]  i8,
   input  logic [8*NCH-1:0]  q8,
   output logic [15:0]       out_data,
   output logic              out_en,
   output logic              out_end,
   output logic [15:0]       packet_count,
   output logic [1:0]        active_mode
);
   localparam int MAXK = (4*NCH > 16) ? 4*NCH : 16;
   localparam int AW   = 15 + MAXK;
   localparam int WCW  = $clog2(PKT_WORDS);
   typedef enum logic {IDLE, RUN} state_t;
   state_t          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d, merged, rest;
   logic [6:0]      fill_q, fill_d, k, total, rem;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [15:0]     pcnt_q, pcnt_d, data_q, data_d, word;
   logic [1:0]      mode_q, mode_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic            en_q, en_d, end_q, end_d, emit, last, same;
   logic [MAXK-1:0] m0, bits;
   int              chan;
   always_comb begin
      chan = (int'(sel_q) < NCH) ? int'(sel_q) : 0;
      m0 = '0;
      for (int c = 0; c < NCH; c++) m0 = {m0[MAXK-5:0], si[2*c+:2], sq[2*c+:2]};
      bits = (mode_q == 2'd0) ? m0 :
             (mode_q == 2'd3) ? MAXK'({i8[8*chan+:8], q8[8*chan+:8]}) :
             (mode_q == 2'd1) ? MAXK'(i8[8*chan+:8]) : MAXK'(q8[8*chan+:8]);
      k      = (mode_q == 2'd0) ? 7'(4*NCH) : (mode_q == 2'd3) ? 7'd16 : 7'd8;
      merged = (acc_q << k) | {{(AW-MAXK){1'b0}}, bits};
      total  = fill_q + k;
      emit   = total >= 7'd16;
      rem    = total - 7'd16;
      word   = 16'(merged >> rem);
      // remainder keeps only the bits below the emitted word
      rest   = merged & ((AW'(1) << rem) - AW'(1));
      last   = emit && wcnt_q == WCW'(PKT_WORDS-1);
      same   = mode_in == mode_q && sel_in == sel_q;
      state_d = state_q;
      acc_d   = acc_q;
      fill_d  = fill_q;
      wcnt_d  = wcnt_q;
      pcnt_d  = pcnt_q;
      mode_d  = mode_q;
      sel_d   = sel_q;
      data_d  = data_q;
      en_d    = 1'b0;
      end_d   = 1'b0;
      if (state_q == IDLE) begin
         if (enable) begin
            state_d = RUN;
            mode_d  = mode_in;
            sel_d   = sel_in;
            acc_d   = '0;
            fill_d  = '0;
            wcnt_d  = '0;
         end
      end else begin
         en_d   = emit;
         end_d  = last;
         data_d = emit ? word : data_q;
         acc_d  = emit ? rest : merged;
         fill_d = emit ? rem : total;
         wcnt_d = last ? '0 : wcnt_q + WCW'(emit);
         if (last) begin
            pcnt_d = pcnt_q + 16'd1;
            if (!enable) begin
               state_d = IDLE;
               acc_d   = '0;
               fill_d  = '0;
            end else if (!same) begin
               mode_d = mode_in;
               sel_d  = sel_in;
               acc_d  = '0;
               fill_d = '0;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         fill_q  <= '0;
         wcnt_q  <= '0;
         pcnt_q  <= '0;
         mode_q  <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         wcnt_q  <= wcnt_d;
         pcnt_q  <= pcnt_d;
         mode_q  <= mode_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         en_q    <= en_d;
         end_q   <= end_d;
      end
   end
   assign out_data     = data_q;
   assign out_en       = en_q;
   assign out_end      = end_q;
   assign packet_count = pcnt_q;
   assign active_mode  = mode_q;
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: randomized and directed stimulus checked against a bit-queue
// reference model of the packer.
module tb_sample_packer;
   localparam int NCH = 3, PKT = 6, SELW = 3;
   logic              clk = 1'b0, reset_n = 1'b1, enable = 1'b0;
   logic [1:0]        mode_in = '0;
   logic [SELW-1:0]   sel_in = '0;
   logic [2*NCH-1:0]  si = '0, sq = '0;
   logic [8*NCH-1:0]  i8 = '0, q8 = '0;
   logic [15:0]       out_data, packet_count;
   logic              out_en, out_end;
   logic [1:0]        active_mode;
   int checks = 0, errors = 0;
   bit              m_run;
   bit              q[$];
   int              m_wc;
   logic [15:0]     m_pc, m_data;
   logic            m_en, m_end;
   logic [1:0]      m_mode;
   logic [SELW-1:0] m_sel;

   sample_packer #(.NCH(NCH), .PKT_WORDS(PKT), .SELW(SELW)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode_in(mode_in), .sel_in(sel_in),
      .si(si), .sq(sq), .i8(i8), .q8(q8), .out_data(out_data), .out_en(out_en),
      .out_end(out_end), .packet_count(packet_count), .active_mode(active_mode));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; q.delete(); m_wc = 0; m_pc = 0; m_data = 0;
      m_en = 0; m_end = 0; m_mode = 0; m_sel = 0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) q.push_back(b[i]);
   endtask

   task automatic model_edge();
      int ch;
      logic [15:0] w;
      m_en = 0; m_end = 0;
      if (!m_run) begin
         if (enable) begin
            m_run = 1; m_mode = mode_in; m_sel = sel_in; q.delete(); m_wc = 0;
         end
      end else begin
         ch = (int'(m_sel) < NCH) ? int'(m_sel) : 0;
         case (m_mode)
            2'd0: for (int c = 0; c < NCH; c++) begin
               q.push_back(si[2*c+1]); q.push_back(si[2*c]);
               q.push_back(sq[2*c+1]); q.push_back(sq[2*c]);
            end
            2'd1: push_byte(i8[8*ch+:8]);
            2'd2: push_byte(q8[8*ch+:8]);
            default: begin push_byte(i8[8*ch+:8]); push_byte(q8[8*ch+:8]); end
         endcase
         if (q.size() >= 16) begin
            w = 0;
            for (int i = 0; i < 16; i++) w = {w[14:0], q.pop_front()};
            m_en = 1; m_data = w;
            if (m_wc == PKT-1) begin
               m_end = 1; m_wc = 0; m_pc = m_pc + 16'd1;
               if (!enable) begin
                  m_run = 0; q.delete();
               end else if (mode_in != m_mode || sel_in != m_sel) begin
                  m_mode = mode_in; m_sel = sel_in; q.delete();
               end
            end else m_wc++;
         end
      end
   endtask

   task automatic check_all();
      chk("out_en", out_en, m_en);
      chk("out_end", out_end, m_end);
      chk("packet_count", packet_count, m_pc);
      chk("active_mode", active_mode, m_mode);
      if (m_en) chk("out_data", out_data, m_data);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_en"}, out_en, 0);
      chk({tag, "_end"}, out_end, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_pc"}, packet_count, 0);
      chk({tag, "_mode"}, active_mode, 0);
   endtask

   task automatic rnd_data();
      si = 6'($urandom); sq = 6'($urandom); i8 = 24'($urandom); q8 = 24'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n, input bit rnd);
      repeat (n) begin
         if (rnd) rnd_data();
         step();
      end
   endtask

   initial begin
      model_reset();
      #1 reset_n = 0;
      #1 check_zero("reset");
      @(negedge clk) reset_n = 1;
      enable = 1; mode_in = 0; sel_in = 0; si = 6'b111001; sq = 6'b111001;
      run(20, 0);
      chk("pc_after_mode0", packet_count, 16'd2);
      run(16, 1);
      mode_in = 1; sel_in = 1; i8 = '0;
      for (int r = 0; r < 40; r++) begin
         i8 = {8'h00, 8'(r), 8'h00};
         step();
      end
      mode_in = 3; sel_in = 2; i8 = {8'h12, 16'h0}; q8 = {8'h34, 16'h0};
      run(20, 0);
      mode_in = 0;
      run(15, 1);
      run(3, 1);
      enable = 0;
      run(20, 1);
      chk("idle_no_en", out_en, 0);
      enable = 1; mode_in = 2; sel_in = 0;
      run(20, 1);
      run(4, 1);
      #2 reset_n = 0;
      #1 check_zero("async_rst");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1;
      run(20, 1);
      for (int n = 0; n < 400; n++) begin
         enable  = $urandom_range(0, 9) != 0;
         mode_in = 2'($urandom);
         sel_in  = 3'($urandom);
         rnd_data();
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
